cache: RTL and testbench

CACHE -- requirements
Module: cache

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_way.sv | 69 ++++++
 rtl/cache.sv | 205 ++++++++++++++++++++
 tb/tb_cache.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types, widths and address field helpers for the 4-way write-back cache.
package cache_pkg;

  localparam int ADDR_W = 25;
  localparam int WORD_W = 32;
  localparam int LINE_W = 128;
  localparam int WORDS  = 4;
  localparam int OFF_W  = 2;
  localparam int WAYS   = 4;
  localparam int BE_W   = 4;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FILL_REQ, FILL_WAIT} state_t;

  function automatic logic [OFF_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] addr_set(input logic [ADDR_W-1:0] a, input int idx);
    return (a >> OFF_W) & ((25'd1 << idx) - 25'd1);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a, input int idx);
    return a >> (OFF_W + idx);
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: tag, valid, dirty and line data per set, with fill and byte-masked word write.
module cache_way
  import cache_pkg::*;
#(
  parameter int cache_index = 2,
  parameter int TAG_W       = ADDR_W - OFF_W - cache_index
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [cache_index-1:0] i_set,
  input  logic                   i_fill,
  input  logic [TAG_W-1:0]       i_tag,
  input  logic [LINE_W-1:0]      i_fill_line,
  input  logic                   i_wr,
  input  logic [OFF_W-1:0]       i_word,
  input  logic [BE_W-1:0]        i_be,
  input  logic [WORD_W-1:0]      i_wdata,
  output logic                   o_valid,
  output logic                   o_dirty,
  output logic [TAG_W-1:0]       o_tag,
  output logic [LINE_W-1:0]      o_line
);

  localparam int SETS = 1 << cache_index;

  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  logic [LINE_W-1:0] data_q [SETS];
  logic [LINE_W-1:0] data_d [SETS];
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (i_fill) begin
      tag_d[i_set]   = i_tag;
      data_d[i_set]  = i_fill_line;
      valid_d[i_set] = 1'b1;
      dirty_d[i_set] = 1'b0;
    end else if (i_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) data_d[i_set][32*int'(i_word) + 8*b +: 8] = i_wdata[8*b +: 8];
      end
      dirty_d[i_set] = 1'b1;
    end
  end

  // Tag and data need no reset: a cleared valid bit hides them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  assign o_valid = valid_q[i_set];
  assign o_dirty = dirty_q[i_set];
  assign o_tag   = tag_q[i_set];
  assign o_line  = data_q[i_set];

endmodule

// File: rtl/cache.sv
// 4-way set-associative write-back/write-allocate cache with LRU replacement and statistics counters.
module cache
  import cache_pkg::*;
#(
  parameter int cache_index = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_p_addr,
  input  logic [BE_W-1:0]   i_p_byte_en,
  input  logic [WORD_W-1:0] i_p_writedata,
  input  logic              i_p_read,
  input  logic              i_p_write,
  output logic [WORD_W-1:0] o_p_readdata,
  output logic              o_p_readdata_valid,
  output logic              o_p_waitrequest,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [BE_W-1:0]   o_m_byte_en,
  output logic [LINE_W-1:0] o_m_writedata,
  output logic              o_m_read,
  output logic              o_m_write,
  input  logic [LINE_W-1:0] i_m_readdata,
  input  logic              i_m_readdata_valid,
  input  logic              i_m_waitrequest,
  output logic [31:0]       cnt_r,
  output logic [31:0]       cnt_w,
  output logic [31:0]       cnt_hit_r,
  output logic [31:0]       cnt_hit_w,
  output logic [31:0]       cnt_wb_r,
  output logic [31:0]       cnt_wb_w
);

  localparam int SETS  = 1 << cache_index;
  localparam int TAG_W = ADDR_W - OFF_W - cache_index;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [BE_W-1:0]   req_be_q, req_be_d;
  logic [WORD_W-1:0] req_data_q, req_data_d;
  logic              req_write_q, req_write_d;
  logic [1:0]        victim_q, victim_d;
  logic              miss_q, miss_d, wb_q, wb_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        age_q [SETS][WAYS];
  logic [1:0]        age_d [SETS][WAYS];
  logic [31:0] cnt_r_q, cnt_r_d, cnt_w_q, cnt_w_d, cnt_hit_r_q, cnt_hit_r_d;
  logic [31:0] cnt_hit_w_q, cnt_hit_w_d, cnt_wb_r_q, cnt_wb_r_d, cnt_wb_w_q, cnt_wb_w_d;

  logic [cache_index-1:0] set_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [OFF_W-1:0]       req_word;
  logic [WAYS-1:0]        way_valid, way_dirty, fill_en, wr_en;
  logic [TAG_W-1:0]       way_tag  [WAYS];
  logic [LINE_W-1:0]      way_line [WAYS];
  logic                   hit, found;
  logic [1:0]             hit_way, vict;
  logic [LINE_W-1:0]      hit_line;

  assign set_idx  = cache_index'(addr_set(req_addr_q, cache_index));
  assign req_tag  = TAG_W'(addr_tag(req_addr_q, cache_index));
  assign req_word = addr_word(req_addr_q);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(.cache_index(cache_index), .TAG_W(TAG_W)) u_way (
      .clk, .rst, .i_set(set_idx),
      .i_fill(fill_en[w]), .i_tag(req_tag), .i_fill_line(i_m_readdata),
      .i_wr(wr_en[w]), .i_word(req_word), .i_be(req_be_q), .i_wdata(req_data_q),
      .o_valid(way_valid[w]), .o_dirty(way_dirty[w]), .o_tag(way_tag[w]), .o_line(way_line[w])
    );
  end

  always_comb begin
    hit = 1'b0;
    hit_way = 2'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && way_tag[w] == req_tag) begin
        hit = 1'b1;
        hit_way = 2'(w);
      end
    end
    hit_line = way_line[hit_way];
    // Lowest invalid way first, otherwise the oldest age (lowest index on a tie).
    found = 1'b0;
    vict = 2'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (!way_valid[w] && !found) begin
        vict = 2'(w);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 1; w < WAYS; w++) begin
        if (age_q[set_idx][w] > age_q[set_idx][vict]) vict = 2'(w);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_be_d    = req_be_q;
    req_data_d  = req_data_q;
    req_write_d = req_write_q;
    victim_d    = victim_q;
    miss_d      = miss_q;
    wb_d        = wb_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    age_d       = age_q;
    fill_en     = '0;
    wr_en       = '0;
    cnt_r_d = cnt_r_q;  cnt_hit_r_d = cnt_hit_r_q;  cnt_wb_r_d = cnt_wb_r_q;
    cnt_w_d = cnt_w_q;  cnt_hit_w_d = cnt_hit_w_q;  cnt_wb_w_d = cnt_wb_w_q;
    unique case (state_q)
      IDLE: if (i_p_read || i_p_write) begin
        req_addr_d  = i_p_addr;
        req_be_d    = i_p_byte_en;
        req_data_d  = i_p_writedata;
        req_write_d = i_p_write;
        miss_d      = 1'b0;
        wb_d        = 1'b0;
        state_d     = COMPARE;
      end
      COMPARE: if (hit) begin
        // Ages still form warm-up ties until every way has been touched; saturate at 3.
        for (int j = 0; j < WAYS; j++) begin
          if (j != int'(hit_way) && age_q[set_idx][j] <= age_q[set_idx][hit_way]
              && age_q[set_idx][j] != 2'd3)
            age_d[set_idx][j] = age_q[set_idx][j] + 2'd1;
        end
        age_d[set_idx][hit_way] = 2'd0;
        if (req_write_q) begin
          wr_en[hit_way] = 1'b1;
          cnt_w_d = cnt_w_q + 32'd1;
          if (!miss_q) cnt_hit_w_d = cnt_hit_w_q + 32'd1;
          if (wb_q)    cnt_wb_w_d  = cnt_wb_w_q + 32'd1;
        end else begin
          rdata_d  = hit_line[32*int'(req_word) +: 32];
          rvalid_d = 1'b1;
          cnt_r_d = cnt_r_q + 32'd1;
          if (!miss_q) cnt_hit_r_d = cnt_hit_r_q + 32'd1;
          if (wb_q)    cnt_wb_r_d  = cnt_wb_r_q + 32'd1;
        end
        state_d = IDLE;
      end else begin
        victim_d = vict;
        miss_d   = 1'b1;
        if (way_valid[vict] && way_dirty[vict]) begin
          wb_d    = 1'b1;
          state_d = WRITEBACK;
        end else begin
          state_d = FILL_REQ;
        end
      end
      WRITEBACK: if (!i_m_waitrequest) state_d = FILL_REQ;
      FILL_REQ:  if (!i_m_waitrequest) state_d = FILL_WAIT;
      FILL_WAIT: if (i_m_readdata_valid) begin
        fill_en[victim_q] = 1'b1;
        state_d = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_addr_q <= '0;  req_be_q <= '0;  req_data_q <= '0;  req_write_q <= 1'b0;
      victim_q <= '0;  miss_q <= 1'b0;  wb_q <= 1'b0;
      rdata_q <= '0;  rvalid_q <= 1'b0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= 2'd0;
      cnt_r_q <= '0;  cnt_w_q <= '0;  cnt_hit_r_q <= '0;
      cnt_hit_w_q <= '0;  cnt_wb_r_q <= '0;  cnt_wb_w_q <= '0;
    end else begin
      state_q <= state_d;
      req_addr_q <= req_addr_d;  req_be_q <= req_be_d;  req_data_q <= req_data_d;
      req_write_q <= req_write_d;
      victim_q <= victim_d;  miss_q <= miss_d;  wb_q <= wb_d;
      rdata_q <= rdata_d;  rvalid_q <= rvalid_d;
      age_q <= age_d;
      cnt_r_q <= cnt_r_d;  cnt_w_q <= cnt_w_d;  cnt_hit_r_q <= cnt_hit_r_d;
      cnt_hit_w_q <= cnt_hit_w_d;  cnt_wb_r_q <= cnt_wb_r_d;  cnt_wb_w_q <= cnt_wb_w_d;
    end
  end

  assign o_p_readdata       = rdata_q;
  assign o_p_readdata_valid = rvalid_q;
  assign o_p_waitrequest    = (state_q != IDLE);
  assign o_m_byte_en        = 4'b1111;
  assign o_m_read           = (state_q == FILL_REQ);
  assign o_m_write          = (state_q == WRITEBACK);
  assign o_m_writedata      = way_line[victim_q];
  assign o_m_addr = (state_q == WRITEBACK) ? {way_tag[victim_q], set_idx, 2'b00} :
                    (state_q == FILL_REQ)  ? {req_addr_q[ADDR_W-1:OFF_W], 2'b00} : '0;

  assign cnt_r     = cnt_r_q;
  assign cnt_w     = cnt_w_q;
  assign cnt_hit_r = cnt_hit_r_q;
  assign cnt_hit_w = cnt_hit_w_q;
  assign cnt_wb_r  = cnt_wb_r_q;
  assign cnt_wb_w  = cnt_wb_w_q;

endmodule

// File: tb/tb_cache.sv
// Directed bench for cache: scoreboard of expected read data plus a behavioural line memory.
module tb_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [24:0]  i_p_addr;
  logic [3:0]   i_p_byte_en;
  logic [31:0]  i_p_writedata;
  logic         i_p_read, i_p_write;
  logic [31:0]  o_p_readdata;
  logic         o_p_readdata_valid, o_p_waitrequest;
  logic [24:0]  o_m_addr;
  logic [3:0]   o_m_byte_en;
  logic [127:0] o_m_writedata;
  logic         o_m_read, o_m_write;
  logic [127:0] i_m_readdata;
  logic         i_m_readdata_valid, i_m_waitrequest;
  logic [31:0]  cnt_r, cnt_w, cnt_hit_r, cnt_hit_w, cnt_wb_r, cnt_wb_w;

  cache #(.cache_index(2)) dut (
    .clk(clk), .rst(rst),
    .i_p_addr(i_p_addr), .i_p_byte_en(i_p_byte_en), .i_p_writedata(i_p_writedata),
    .i_p_read(i_p_read), .i_p_write(i_p_write),
    .o_p_readdata(o_p_readdata), .o_p_readdata_valid(o_p_readdata_valid),
    .o_p_waitrequest(o_p_waitrequest),
    .o_m_addr(o_m_addr), .o_m_byte_en(o_m_byte_en), .o_m_writedata(o_m_writedata),
    .o_m_read(o_m_read), .o_m_write(o_m_write),
    .i_m_readdata(i_m_readdata), .i_m_readdata_valid(i_m_readdata_valid),
    .i_m_waitrequest(i_m_waitrequest),
    .cnt_r(cnt_r), .cnt_w(cnt_w), .cnt_hit_r(cnt_hit_r), .cnt_hit_w(cnt_hit_w),
    .cnt_wb_r(cnt_wb_r), .cnt_wb_w(cnt_wb_w)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0]  sb_q [$];
  logic [127:0] mem_w [int];
  logic [31:0]  gold [int];

  int mem_reads = 0, mem_writes = 0, rd_hi = 0, rd_stalls = 0, pwait_low = 0;
  int stall = 0;
  bit hold_fill = 0, fill_held = 0, pending = 0;
  logic [22:0]  pend_line;
  logic [24:0]  wb_addr;
  logic [127:0] wb_data;

  function automatic logic [127:0] pat_line(input logic [22:0] n);
    logic [31:0] nn;
    nn = {9'd0, n};
    return {nn, nn + 32'd1, 32'hf0f0_0505, 32'hffff_eeee};
  endfunction

  function automatic logic [127:0] mem_line(input logic [22:0] n);
    if (mem_w.exists(int'(n))) return mem_w[int'(n)];
    return pat_line(n);
  endfunction

  function automatic logic [31:0] gold_word(input logic [24:0] a);
    logic [127:0] l;
    if (gold.exists(int'(a))) return gold[int'(a)];
    l = pat_line(a[24:2]);
    return l[32*int'(a[1:0]) +: 32];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory side: one-cycle fill latency after the read is granted, optional read stall.
  initial begin
    i_m_waitrequest = 1'b0;
    i_m_readdata_valid = 1'b0;
    i_m_readdata = '0;
    forever begin
      @(negedge clk);
      i_m_readdata_valid = 1'b0;
      if (rst) begin
        pending = 0;
        i_m_waitrequest = 1'b0;
      end else begin
        if ((o_m_read || o_m_write) && !o_p_waitrequest) pwait_low++;
        if (pending && !hold_fill) begin
          i_m_readdata_valid = 1'b1;
          i_m_readdata = mem_line(pend_line);
          pending = 0;
        end else if (pending) begin
          fill_held = 1;
        end else if (o_m_read) begin
          rd_hi++;
          if (stall > 0) begin
            i_m_waitrequest = 1'b1;
            stall--;
            rd_stalls++;
          end else begin
            i_m_waitrequest = 1'b0;
            pending = 1;
            pend_line = o_m_addr[24:2];
            mem_reads++;
          end
        end else if (o_m_write) begin
          i_m_waitrequest = 1'b0;
          mem_writes++;
          wb_addr = o_m_addr;
          wb_data = o_m_writedata;
          mem_w[int'(o_m_addr[24:2])] = o_m_writedata;
        end else begin
          i_m_waitrequest = 1'b0;
        end
      end
    end
  end

  task automatic do_op(input bit wr, input logic [24:0] addr, input logic [3:0] be,
                       input logic [31:0] data);
    int budget;
    bit done;
    logic [31:0] w;
    @(negedge clk);
    i_p_addr = addr;
    i_p_byte_en = be;
    i_p_writedata = data;
    i_p_read = !wr;
    i_p_write = wr;
    if (wr) begin
      w = gold_word(addr);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = data[8*b +: 8];
      gold[int'(addr)] = w;
    end else begin
      sb_q.push_back(gold_word(addr));
    end
    @(posedge clk);
    #1;
    i_p_read = 1'b0;
    i_p_write = 1'b0;
    budget = 0;
    done = 0;
    while (!done && budget < 200) begin
      @(negedge clk);
      budget++;
      if (!o_p_waitrequest) done = 1;
    end
    check("op_complete", 128'(done), 128'(1));
    if (!wr) begin
      check("rvalid", 128'(o_p_readdata_valid), 128'(1));
      if (sb_q.size() > 0) check("rdata", 128'(o_p_readdata), 128'(sb_q.pop_front()));
      @(negedge clk);
      check("rvalid_one_cycle", 128'(o_p_readdata_valid), 128'(0));
    end else begin
      check("w_no_rvalid", 128'(o_p_readdata_valid), 128'(0));
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_outs"}, 128'({o_p_readdata_valid, o_m_read, o_m_write, o_p_waitrequest}), 128'(0));
    check({tag, "_rdata"}, 128'(o_p_readdata), 128'(0));
    check({tag, "_cnts"}, {cnt_r, cnt_w, cnt_hit_r, cnt_hit_w}, 128'(0));
    check({tag, "_cnts_wb"}, 128'({cnt_wb_r, cnt_wb_w}), 128'(0));
  endtask

  initial begin
    int r0, w0, b;
    rst = 1'b1;
    i_p_addr = '0; i_p_byte_en = '0; i_p_writedata = '0;
    i_p_read = 1'b0; i_p_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1; rst = 1'b0;

    // Read miss then hit in the same line.
    r0 = mem_reads;
    do_op(0, 25'd0, 4'h0, 32'h0);
    check("miss_mem_reads", 128'(mem_reads - r0), 128'(1));
    check("miss_cnt_r", 128'(cnt_r), 128'(1));
    check("miss_cnt_hit_r", 128'(cnt_hit_r), 128'(0));
    r0 = mem_reads;
    do_op(0, 25'd3, 4'h0, 32'h0);
    check("hit_mem_reads", 128'(mem_reads - r0), 128'(0));
    check("hit_cnt_hit_r", 128'(cnt_hit_r), 128'(1));

    // Write hit with partial byte mask, then read back.
    do_op(1, 25'd1, 4'b0011, 32'h1234_5678);
    check("whit_cnt_hit_w", 128'(cnt_hit_w), 128'(1));
    check("whit_cnt_w", 128'(cnt_w), 128'(1));
    do_op(0, 25'd1, 4'h0, 32'h0);

    // Fill set 0 with three more tags, then a fourth evicts the dirty line.
    w0 = mem_writes;
    do_op(0, 25'd16, 4'h0, 32'h0);
    do_op(0, 25'd32, 4'h0, 32'h0);
    do_op(0, 25'd48, 4'h0, 32'h0);
    check("no_early_wb", 128'(mem_writes - w0), 128'(0));
    do_op(0, 25'd67, 4'h0, 32'h0);
    check("evict_wb_count", 128'(mem_writes - w0), 128'(1));
    check("evict_wb_addr", 128'(wb_addr), 128'(0));
    check("evict_wb_data", wb_data, {32'd0, 32'd1, 32'hf0f0_5678, 32'hffff_eeee});
    check("evict_cnt_wb_r", 128'(cnt_wb_r), 128'(1));

    // Refetch of the evicted line must see the written-back merge; LRU victim is clean.
    w0 = mem_writes;
    do_op(0, 25'd1, 4'h0, 32'h0);
    check("refetch_no_wb", 128'(mem_writes - w0), 128'(0));

    // Write miss allocates and merges.
    do_op(1, 25'd4, 4'b1111, 32'hdead_beef);
    check("wmiss_cnt_w", 128'(cnt_w), 128'(2));
    check("wmiss_cnt_hit_w", 128'(cnt_hit_w), 128'(1));
    do_op(0, 25'd4, 4'h0, 32'h0);
    check("cnt_r_total", 128'(cnt_r), 128'(9));

    // Memory back-pressure during a fill.
    stall = 5;
    r0 = rd_stalls;
    b = rd_hi;
    do_op(0, 25'd9, 4'h0, 32'h0);
    check("bp_stalls", 128'(rd_stalls - r0), 128'(5));
    check("bp_read_held", 128'(rd_hi - b), 128'(6));
    check("bp_pwait_high", 128'(pwait_low), 128'(0));

    // Reset while the fill is outstanding.
    hold_fill = 1;
    fill_held = 0;
    @(negedge clk);
    i_p_addr = 25'd12;
    i_p_read = 1'b1;
    @(posedge clk); #1; i_p_read = 1'b0;
    b = 0;
    while (!fill_held && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("reached_fill_wait", 128'(fill_held), 128'(1));
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; hold_fill = 0;
    @(negedge clk);
    check_idle_zero("midreset");
    r0 = mem_reads;
    do_op(0, 25'd12, 4'h0, 32'h0);
    check("after_reset_miss", 128'(mem_reads - r0), 128'(1));
    check("after_reset_hit_r", 128'(cnt_hit_r), 128'(0));
    check("after_reset_cnt_r", 128'(cnt_r), 128'(1));
    check("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
